cfg_write_scheduler: RTL

Sequences all writes into the cube's configuration register space and shares its single 8-bit write bus between two requesters: the host UART byte stream and the local animation stepper (push-button or auto-cycle timer). The bus carries a 4-bit register index in `[7:4]` and 4-bit data in `[3:0]`. The bus is decoded every cycle, so this block drives the idle byte `8'hFF` except during the single cycle of each write; index 15 decodes to no register. The block sits between the UART receiver and the config register file, and keeps a shadow of the current animation selection.

---
 rtl/cfg_pkg.sv | 8 +
 rtl/cfg_fifo.sv | 38 +++
 rtl/cfg_write_scheduler.sv | 106 ++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// cfg_pkg: register indices, idle bus byte and scheduler state encoding.
package cfg_pkg;
    localparam logic [3:0] CFG_IDX_MODE   = 4'd0;
    localparam logic [3:0] CFG_IDX_BRIGHT = 4'd1;
    localparam logic [3:0] CFG_IDX_ANIM   = 4'd4;
    localparam logic [7:0] CFG_IDLE_BYTE  = 8'hFF;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} cfg_sched_state_t;
endpackage

// File: rtl/cfg_fifo.sv
// cfg_fifo: small synchronous byte FIFO buffering the UART stream.
module cfg_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] data,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    // storage write; contents need no reset since r_cnt guards them
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr] <= data;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign full  = r_cnt == (AW+1)'(DEPTH);
    assign empty = r_cnt == '0;
    assign head  = r_mem[r_rd];
endmodule

// File: rtl/cfg_write_scheduler.sv
// cfg_write_scheduler: arbitrates UART and local animation writes onto the config bus.
module cfg_write_scheduler
    import cfg_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int AUTO_PERIOD = 50_000_000,
    parameter int NUM_ANIM    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       button_pulse,
    input  logic       auto_en,
    output logic [7:0] cfg_byte,
    output logic       cfg_strobe,
    output logic [3:0] anim_shadow,
    output logic       overflow
);
    localparam int TW = $clog2(AUTO_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);
    localparam logic [3:0]    ANIM_LAST  = 4'(NUM_ANIM - 1);
    cfg_sched_state_t r_state, w_state_nxt;
    logic [7:0]    r_byte;
    logic          r_strobe;
    logic          r_src_uart;
    logic          r_last_local;
    logic          r_local_pend;
    logic          r_overflow;
    logic [3:0]    r_shadow;
    logic [TW-1:0] r_timer;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic          w_grant_uart;
    logic          w_grant_local;
    logic          w_push;
    logic          w_tick;
    logic          w_override;
    logic [3:0]    w_anim_next;
    cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_grant_uart),
        .data  (rx_data),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );
    assign w_push      = rx_valid && (!w_full || w_grant_uart);
    assign w_tick      = auto_en && r_timer == TIMER_LAST;
    assign w_override  = r_strobe && r_src_uart && r_byte[7:4] == CFG_IDX_ANIM;
    assign w_anim_next = r_shadow >= ANIM_LAST ? 4'd0 : r_shadow + 4'd1;
    // next state and round-robin grant; grants only happen outside ISSUE
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_uart  = 1'b0;
        w_grant_local = 1'b0;
        case (r_state)
            ISSUE: w_state_nxt = GAP;
            IDLE, GAP: begin
                w_state_nxt   = (!w_empty || r_local_pend) ? ISSUE : IDLE;
                w_grant_uart  = !w_empty && (!r_local_pend || r_last_local);
                w_grant_local = r_local_pend && !w_grant_uart;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    // state register plus the registered bus byte for the following ISSUE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_byte       <= CFG_IDLE_BYTE;
            r_strobe     <= 1'b0;
            r_src_uart   <= 1'b0;
            r_last_local <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_byte   <= w_grant_uart ? w_head : w_grant_local ? {CFG_IDX_ANIM, w_anim_next} : CFG_IDLE_BYTE;
            r_strobe <= w_grant_uart || w_grant_local;
            if (w_grant_uart || w_grant_local) begin
                r_src_uart   <= w_grant_uart;
                r_last_local <= w_grant_local;
            end
        end
    end
    // local request flag, auto timer, sticky overflow and animation shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_local_pend <= 1'b0;
            r_timer      <= '0;
            r_overflow   <= 1'b0;
            r_shadow     <= 4'd0;
        end else begin
            r_local_pend <= button_pulse || w_tick || (r_local_pend && !w_grant_local);
            r_timer      <= (!auto_en || w_override || w_tick) ? '0 : r_timer + 1'b1;
            r_overflow   <= r_overflow || (rx_valid && !w_push);
            if (r_strobe && r_byte[7:4] == CFG_IDX_ANIM) r_shadow <= r_byte[3:0];
        end
    end
    assign cfg_byte    = r_byte;
    assign cfg_strobe  = r_strobe;
    assign anim_shadow = r_shadow;
    assign overflow    = r_overflow;
endmodule
